// File: rtl/cmd_streamer.sv
// cmd_streamer: fetches a program of 64-bit commands from memory through a small prefetch FIFO and streams them to a command processor.
module cmd_streamer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] base_addr,
    input  logic [15:0] cmd_count,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] issued_count,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_valid,
    input  logic [63:0] mem_rdata,
    output logic        cmd_valid,
    output logic [63:0] cmd_data,
    input  logic        cmd_ready,
    input  logic        halted
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
    logic [1:0]    state;
    logic [63:0]   base;
    logic [15:0]   cnt, fetched, fetched_next;
    logic          outstanding, out_next, req_q, granted, push, pop, start_ok, want_req;
    logic [63:0]   fifo [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, occ_next;
    assign mem_we       = 1'b0;
    assign mem_wdata    = '0;
    assign busy         = (state == RUN) || (state == FLUSH);
    assign done         = state == DONE;
    assign mem_req      = req_q && !halted;
    assign cmd_valid    = (state == RUN) && (occ != '0) && !halted;
    assign cmd_data     = fifo[rd_ptr];
    assign granted      = mem_req && mem_gnt;
    assign push         = mem_valid && outstanding && (state == RUN);
    assign pop          = cmd_valid && cmd_ready;
    assign start_ok     = start && ((state == IDLE) || (state == DONE));
    assign out_next     = granted || (outstanding && !mem_valid);
    assign occ_next     = occ + (AW+1)'(push) - (AW+1)'(pop);
    assign fetched_next = fetched + 16'(granted);
    // a new read is raised only once the previous one has landed, so outstanding never exceeds one
    assign want_req     = !out_next && (occ_next < (AW+1)'(FIFO_DEPTH)) && (fetched_next < cnt);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            base         <= '0;
            cnt          <= '0;
            fetched      <= '0;
            outstanding  <= 1'b0;
            req_q        <= 1'b0;
            mem_addr     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            issued_count <= '0;
            aborted      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
        end else if (start_ok) begin
            base         <= base_addr;
            cnt          <= cmd_count;
            fetched      <= '0;
            outstanding  <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            issued_count <= '0;
            aborted      <= 1'b0;
            state        <= (cmd_count == '0) ? DONE : RUN;
            req_q        <= cmd_count != '0;
            if (cmd_count != '0) mem_addr <= base_addr;
        end else if (state == RUN) begin
            outstanding <= out_next;
            fetched     <= fetched_next;
            occ         <= occ_next;
            if (push) begin
                fifo[wr_ptr] <= mem_rdata;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + AW'(1);
                issued_count <= issued_count + 16'd1;
            end
            if (halted) begin
                req_q <= 1'b0;
                state <= FLUSH;
            end else if (issued_count == cnt) begin
                state <= DONE;
            end else if (!(req_q && !mem_gnt)) begin
                req_q <= want_req;
                if (want_req) mem_addr <= base + 64'(fetched_next);
            end
        end else if (state == FLUSH) begin
            outstanding <= outstanding && !mem_valid;
            if (!outstanding) begin
                state   <= DONE;
                aborted <= 1'b1;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                occ     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cmd_streamer.sv
// tb_cmd_streamer: vector table, corner sequences and random programs checked against an address/word model.
module tb_cmd_streamer;
    localparam int DEPTH = 4;
    logic        clk = 0, rst, start, busy, done, aborted, mem_req, mem_we, mem_gnt = 0, mem_valid = 0;
    logic        cmd_valid, cmd_ready = 0, halted = 0;
    logic [63:0] base_addr, mem_addr, mem_wdata, mem_rdata = '0, cmd_data;
    logic [15:0] cmd_count, issued_count;
    int          tests = 0, fails = 0;
    int          gnt_hold = 0, vlat = 2, rmode = 0, stall_until = 0, halt_at = -1, cyc = 0;
    int          g0 = 0, c0 = 0, timer = -1, req_wait = 0;
    logic [63:0] resp_addr = '0, held_addr = '0, prev_data = '0;
    logic        prev_stall = 0;
    logic [63:0] grants[$], got[$];

    typedef struct {
        logic [63:0] base;
        int          cnt, hold, lat, rm, halt, exp_iss;
        logic        exp_ab;
    } vec_t;
    vec_t vecs[7];

    cmd_streamer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .cmd_count(cmd_count),
        .busy(busy), .done(done), .aborted(aborted), .issued_count(issued_count),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0F0F, a[63:32] + 32'h1234_5678};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory and command-processor environment; drives at negedge, observes 1-2 time units later
    always begin
        @(negedge clk);
        cyc++;
        if (timer > 0) timer--;
        mem_valid = 0;
        mem_gnt = 0;
        if (timer == 0) begin
            mem_valid = 1;
            mem_rdata = word(resp_addr);
            timer = -1;
        end
        halted = (halt_at >= 0) && (got.size() >= halt_at);
        cmd_ready = (cyc < stall_until) ? 1'b0 : (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        if (req_wait > 0 && rst && !halted) begin
            chk("req_held", {63'd0, mem_req}, 64'd1);
            chk("addr_held", mem_addr, held_addr);
        end
        if (mem_req && req_wait >= gnt_hold) mem_gnt = 1;
        else if (mem_req) begin
            if (req_wait == 0) held_addr = mem_addr;
            req_wait++;
        end else req_wait = 0;
        #1;
        if (prev_stall && cmd_valid) chk("data_stable", cmd_data, prev_data);
        prev_stall = cmd_valid && !cmd_ready;
        prev_data = cmd_data;
        if (cmd_valid && cmd_ready && rst) got.push_back(cmd_data);
        if (halted && busy) begin
            chk("halt_cmd_valid", {63'd0, cmd_valid}, 64'd0);
            chk("halt_mem_req", {63'd0, mem_req}, 64'd0);
        end
        if (mem_req && mem_gnt) begin
            chk("one_outstanding", {63'd0, timer >= 0}, 64'd0);
            grants.push_back(mem_addr);
            resp_addr = mem_addr;
            timer = vlat;
            req_wait = 0;
            chk("prefetch_bound", {63'd0, (grants.size() - g0) - (got.size() - c0) <= DEPTH}, 64'd1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_run(input logic [63:0] b, input int n, input int h);
        g0 = grants.size();
        c0 = got.size();
        halt_at = (h >= 0) ? c0 + h : -1;
        base_addr = b;
        cmd_count = 16'(n);
        start = 1;
        cycles(1);
        start = 0;
        if (n == 0) begin
            chk("zero_done", {63'd0, done}, 64'd1);
            chk("zero_no_req", {63'd0, mem_req}, 64'd0);
        end else if (h < 0) begin
            chk("first_req", {63'd0, mem_req}, 64'd1);
            chk("first_addr", mem_addr, b);
            chk("run_busy", {62'd0, busy, done}, 64'd2);
        end
    endtask

    task automatic finish_run(input logic [63:0] b, input int n, input int exp_iss, input logic exp_ab);
        int k;
        for (k = 0; k < 3000 && !done; k++) cycles(1);
        chk("done_reached", {63'd0, done}, 64'd1);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("issued_count", {48'd0, issued_count}, 64'(exp_iss));
        chk("aborted", {63'd0, aborted}, {63'd0, exp_ab});
        chk("handed_total", 64'(got.size() - c0), 64'(exp_iss));
        for (int i = 0; i < exp_iss && c0 + i < got.size(); i++) chk("cmd_word", got[c0 + i], word(b + 64'(i)));
        if (!exp_ab) chk("read_total", 64'(grants.size() - g0), 64'(n));
        else chk("read_bound", {63'd0, grants.size() - g0 >= exp_iss && grants.size() - g0 <= n}, 64'd1);
        for (int i = 0; g0 + i < grants.size(); i++) chk("read_addr", grants[g0 + i], b + 64'(i));
        halt_at = -1;
        cycles(2);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_flags", {59'd0, busy, done, aborted, mem_req, cmd_valid}, 64'd0);
        chk("rst_issued", {48'd0, issued_count}, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_data", cmd_data, 64'd0);
        chk("rst_we", {mem_wdata[62:0], mem_we}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{64'h100, 3, 0, 2, 0, -1, 3, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 1, 0, -1, 2, 1'b0};
        vecs[2] = '{64'h55, 0, 0, 1, 0, -1, 0, 1'b0};
        vecs[3] = '{64'h2000, 5, 5, 1, 0, -1, 5, 1'b0};
        vecs[4] = '{64'h300, 6, 0, 6, 0, 2, 2, 1'b1};
        vecs[5] = '{64'h4000, 7, 2, 3, 1, -1, 7, 1'b0};
        vecs[6] = '{64'h10, 16, 1, 1, 1, -1, 16, 1'b0};
        rst = 0;
        start = 0;
        base_addr = '0;
        cmd_count = '0;
        cycles(3);
        chk_reset_outputs();
        rst = 1;
        cycles(1);
        foreach (vecs[i]) begin
            gnt_hold = vecs[i].hold;
            vlat = vecs[i].lat;
            rmode = vecs[i].rm;
            start_run(vecs[i].base, vecs[i].cnt, vecs[i].halt);
            finish_run(vecs[i].base, vecs[i].cnt, vecs[i].exp_iss, vecs[i].exp_ab);
        end
        // consumer stalled: prefetch must stop at the FIFO depth
        gnt_hold = 0;
        vlat = 1;
        rmode = 0;
        stall_until = cyc + 25;
        start_run(64'h800, 8, -1);
        cycles(18);
        chk("stall_reads", 64'(grants.size() - g0), 64'(DEPTH));
        chk("stall_no_req", {63'd0, mem_req}, 64'd0);
        chk("stall_valid", {63'd0, cmd_valid}, 64'd1);
        chk("stall_head", cmd_data, word(64'h800));
        finish_run(64'h800, 8, 8, 1'b0);
        // start while running is ignored
        vlat = 3;
        start_run(64'hB00, 5, -1);
        cycles(3);
        base_addr = 64'hDEAD;
        cmd_count = 16'd2;
        start = 1;
        cycles(1);
        start = 0;
        chk("ignored_start_busy", {63'd0, busy}, 64'd1);
        finish_run(64'hB00, 5, 5, 1'b0);
        // reset in the middle of a run, with a response still in flight
        vlat = 8;
        start_run(64'h900, 6, -1);
        cycles(3);
        rst = 0;
        #1;
        chk_reset_outputs();
        cycles(2);
        rst = 1;
        cycles(10);
        chk("stale_busy", {62'd0, busy, done}, 64'd0);
        chk("stale_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        chk("stale_handed", 64'(got.size() - c0), 64'd0);
        vlat = 2;
        start_run(64'hA00, 4, -1);
        finish_run(64'hA00, 4, 4, 1'b0);
        for (int r = 0; r < 10; r++) begin
            logic [63:0] b;
            int n, h;
            b = {$urandom, $urandom};
            n = $urandom_range(0, 9);
            h = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            gnt_hold = $urandom_range(0, 3);
            vlat = $urandom_range(1, 4);
            rmode = $urandom_range(0, 1);
            start_run(b, n, h);
            finish_run(b, n, (h >= 0) ? h : n, h >= 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cmd_streamer.md
CMD_STREAMER -- requirements
Module: cmd_streamer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, prefetch FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle launch pulse.
REQ-005 SHALL have port base_addr  input  64  word address of first command, latched at accepted start.
REQ-006 SHALL have port cmd_count  input  16  number of commands, latched at accepted start.
REQ-007 SHALL have port busy  output  1  high while streaming.
REQ-008 SHALL have port done  output  1  high from completion until next accepted start.
REQ-009 SHALL have port aborted  output  1  valid with done; high if the program ended on halted.
REQ-010 SHALL have port issued_count  output  16  commands handed over in the current/last run.
REQ-011 SHALL have ports mem_req/mem_we  output  1/1,  mem_addr/mem_wdata  output  64/64  memory request (arbiter client side).
REQ-012 SHALL have ports mem_gnt/mem_valid  input  1/1,  mem_rdata  input  64  grant and read response.
REQ-013 SHALL have ports cmd_valid  output  1,  cmd_data  output  64,  cmd_ready  input  1  command stream to the command processor.
REQ-014 SHALL have port halted  input  1  command processor halted flag.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH, DONE; busy=1 in RUN and FLUSH only.
REQ-016 start SHALL be accepted only in IDLE or DONE; start in RUN/FLUSH SHALL be ignored.
REQ-017 Accepted start with cmd_count=0 SHALL go to DONE next cycle, aborted=0, no memory request.
REQ-018 Accepted start with cmd_count>0 SHALL go to RUN, clear issued_count, fetch pointer, FIFO, done, aborted.
REQ-019 mem_we and mem_wdata SHALL be constant 0 (read-only client).
REQ-020 At most one memory read outstanding; a new request SHALL be raised only if FIFO occupancy + outstanding < FIFO_DEPTH and fetched < cmd_count.
REQ-021 First mem_req SHALL assert the cycle after the accepting start edge, mem_addr=base_addr.
REQ-022 mem_req and mem_addr SHALL hold stable until sampled with mem_gnt=1; mem_req SHALL drop the following cycle.
REQ-023 Request k (0-based) SHALL use mem_addr = base_addr + k, modulo 2^64 (wrap allowed).
REQ-024 Response arrives as one mem_valid pulse >=1 cycle after grant; mem_rdata SHALL be pushed into the FIFO that edge; mem_valid with nothing outstanding SHALL be ignored.
REQ-025 cmd_valid SHALL equal (state==RUN && FIFO not empty); cmd_data SHALL be the FIFO head, no combinational path from mem_rdata.
REQ-026 Handover occurs on cmd_valid && cmd_ready; FIFO pops and issued_count increments that edge; cmd_data stable while cmd_valid && !cmd_ready.
REQ-027 Simultaneous push and pop SHALL be supported, occupancy unchanged; full FIFO never occurs by REQ-020.
REQ-028 RUN->DONE (aborted=0) the cycle after issued_count reaches cmd_count.
REQ-029 halted=1 in RUN SHALL force cmd_valid=0 that cycle, stop new requests, and go to FLUSH; halted wins over a same-cycle handover (no pop).
REQ-030 FLUSH SHALL hold until no read is outstanding (late response discarded), then clear FIFO and go to DONE with aborted=1.
REQ-031 An ungranted mem_req at halt SHALL be withdrawn immediately (not outstanding).

Reset
REQ-032 rst low SHALL asynchronously force IDLE, FIFO empty, no outstanding, busy=0, done=0, aborted=0, issued_count=0, mem_req=0, mem_addr=0, cmd_valid=0, cmd_data=0.
REQ-033 Reset mid-RUN SHALL drop mem_req/cmd_valid immediately; a response arriving after reset release SHALL be ignored.

Verification
REQ-034 base_addr=0x100, count=3, gnt immediate, valid 2 cycles later, ready=1 -> addrs 0x100,0x101,0x102; cmd_data = memory words in order; done, issued_count=3, aborted=0.
REQ-035 count=8, cmd_ready=0 for 20 cycles -> exactly FIFO_DEPTH reads then mem_req idle; cmd_data stable; after ready=1 all 8 issued in order.
REQ-036 mem_gnt withheld 5 cycles -> mem_req/mem_addr unchanged 5 cycles, single grant, single FIFO push.
REQ-037 halted=1 after 2 of 6 commands with one read outstanding -> cmd_valid=0 same cycle, response discarded, done=1, aborted=1, issued_count=2.
REQ-038 base_addr=0xFFFF_FFFF_FFFF_FFFF, count=2 -> addrs 0xFFFF_FFFF_FFFF_FFFF then 0x0; count=0 -> done next cycle, no mem_req.
REQ-039 rst low mid-RUN, then restart with new base -> all outputs reset values; stale mem_valid ignored; second run correct.
